// File: rtl/pool_result_collector.sv
// Collects pooled results into a first-word-fall-through FIFO and tags the
// final result of each outWidth x outHeight frame on the way out.
module pool_result_collector #(
    parameter int bitwidth  = 8,
    parameter int outWidth  = 4,
    parameter int outHeight = 4,
    parameter int depth     = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [bitwidth-1:0]       average_in,
    input  logic                      averageReady_in,
    output logic [bitwidth-1:0]       data_out,
    output logic                      valid_out,
    input  logic                      ready_in,
    output logic                      last_out,
    output logic [$clog2(depth):0]    count_out,
    output logic                      overflow_out
);

    localparam int PW   = $clog2(depth);
    localparam int CW   = PW + 1;
    localparam int COLW = (outWidth > 1) ? $clog2(outWidth) : 1;
    localparam int ROWW = (outHeight > 1) ? $clog2(outHeight) : 1;

    logic [bitwidth-1:0] mem_q [depth];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [COLW-1:0] col_q, col_d;
    logic [ROWW-1:0] row_q, row_d;
    logic            strobe_q, strobe_d;
    logic            overflow_q, overflow_d;

    logic capture;
    logic full;
    logic pop;
    logic push;
    logic col_end;
    logic row_end;

    always_comb begin
        capture    = averageReady_in & ~strobe_q;
        full       = (count_q == CW'(depth));
        valid_out  = (count_q != '0);
        pop        = valid_out & ready_in;
        // A full FIFO can still accept a capture when a pop frees the head slot.
        push       = capture & (~full | pop);
        col_end    = (col_q == COLW'(outWidth - 1));
        row_end    = (row_q == ROWW'(outHeight - 1));

        strobe_d   = averageReady_in;
        overflow_d = overflow_q | (capture & full & ~pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        col_d      = col_q;
        row_d      = row_q;

        if (push) begin
            wr_ptr_d = PW'(wr_ptr_q + 1);
        end
        if (pop) begin
            rd_ptr_d = PW'(rd_ptr_q + 1);
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : ROWW'(row_q + 1);
            end else begin
                col_d = COLW'(col_q + 1);
            end
        end
        if (push && !pop) begin
            count_d = CW'(count_q + 1);
        end else if (pop && !push) begin
            count_d = CW'(count_q - 1);
        end

        data_out     = mem_q[rd_ptr_q];
        last_out     = valid_out & col_end & row_end;
        count_out    = count_q;
        overflow_out = overflow_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            strobe_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            col_q      <= col_d;
            row_q      <= row_d;
            strobe_q   <= strobe_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is left unreset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= average_in;
        end
    end

endmodule

// File: tb/tb_pool_result_collector.sv
// Directed bench for pool_result_collector: a queue-based model checked every
// cycle, plus literal expectations for each scenario.
module tb_pool_result_collector;

    localparam int BW    = 8;
    localparam int OW    = 4;
    localparam int OH    = 4;
    localparam int DEPTH = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [BW-1:0] average_in;
    logic          averageReady_in;
    logic [BW-1:0] data_out;
    logic          valid_out;
    logic          ready_in;
    logic          last_out;
    logic [3:0]    count_out;
    logic          overflow_out;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pool_result_collector #(
        .bitwidth (BW),
        .outWidth (OW),
        .outHeight(OH),
        .depth    (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .average_in     (average_in),
        .averageReady_in(averageReady_in),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .last_out       (last_out),
        .count_out      (count_out),
        .overflow_out   (overflow_out)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of stored results and a running pop count.
    logic [BW-1:0] m_q[$];
    bit            m_prev;
    bit            m_ovf;
    int            m_pops;
    bit            m_cap;
    bit            m_pop;
    bit            m_full;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_prev = 1'b0;
            m_ovf  = 1'b0;
            m_pops = 0;
        end else begin
            m_cap  = averageReady_in && !m_prev;
            m_prev = averageReady_in;
            m_pop  = (m_q.size() != 0) && ready_in;
            m_full = (m_q.size() == DEPTH);
            if (m_pop) begin
                void'(m_q.pop_front());
                m_pops++;
            end
            if (m_cap) begin
                if (!m_full || m_pop) m_q.push_back(average_in);
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        #2;
        if (!reset) begin
            checkOutput("model_count", 32'(count_out), 32'(m_q.size()));
            checkOutput("model_valid", 32'(valid_out), 32'(m_q.size() != 0));
            checkOutput("model_overflow", 32'(overflow_out), 32'(m_ovf));
            if (m_q.size() != 0) begin
                checkOutput("model_data", 32'(data_out), 32'(m_q[0]));
                checkOutput("model_last", 32'(last_out), 32'((m_pops % (OW * OH)) == (OW * OH - 1)));
            end
        end
    end

    task automatic applyStimulus(input logic strobe, input logic [BW-1:0] value, input logic rdy);
        averageReady_in = strobe;
        average_in      = value;
        ready_in        = rdy;
        @(negedge clock);
    endtask

    task automatic pulseStrobe(input logic [BW-1:0] value, input logic rdy);
        applyStimulus(1'b1, value, rdy);
        applyStimulus(1'b0, value, rdy);
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic drain(input int n);
        repeat (n) applyStimulus(1'b0, '0, 1'b1);
    endtask

    // Pushes a result every other cycle while popping, and records which pop carried last_out.
    task automatic runFrame(input bit stalls, input string tag);
        int pushes  = 0;
        int pops    = 0;
        int lastAt  = 0;
        int lastCnt = 0;
        logic s;
        logic r;
        for (int cyc = 0; cyc < 400 && pops < 17; cyc++) begin
            s = (pushes < 20) ? ~averageReady_in : 1'b0;
            if (s) pushes++;
            r = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            averageReady_in = s;
            average_in      = BW'(8'h30 + pushes);
            ready_in        = r;
            if (valid_out && r) begin
                pops++;
                if (last_out) begin
                    lastCnt++;
                    lastAt = pops;
                end
            end
            @(negedge clock);
        end
        checkOutput({tag, "_pops"}, 32'(pops), 32'd17);
        checkOutput({tag, "_last_count"}, 32'(lastCnt), 32'd1);
        checkOutput({tag, "_last_position"}, 32'(lastAt), 32'd16);
        drain(12);
        checkOutput({tag, "_drained"}, 32'(count_out), 32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        average_in      = '0;
        averageReady_in = 1'b0;
        ready_in        = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("reset_valid", 32'(valid_out), 32'd0);
        checkOutput("reset_count", 32'(count_out), 32'd0);
        checkOutput("reset_overflow", 32'(overflow_out), 32'd0);
        checkOutput("reset_last", 32'(last_out), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Single capture becomes visible exactly one cycle later.
        applyStimulus(1'b1, 8'h2A, 1'b0);
        checkOutput("single_valid", 32'(valid_out), 32'd1);
        checkOutput("single_data", 32'(data_out), 32'h2A);
        checkOutput("single_count", 32'(count_out), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("single_hold_data", 32'(data_out), 32'h2A);
        drain(1);
        checkOutput("single_popped", 32'(count_out), 32'd0);

        // Held strobe gives a single capture of the first value.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, BW'(8'h10 + i), 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("held_count", 32'(count_out), 32'd1);
        checkOutput("held_data", 32'(data_out), 32'h10);
        drain(1);

        // Nine strobes into eight slots.
        for (int i = 0; i < 9; i++) pulseStrobe(BW'(8'h50 + i), 1'b0);
        checkOutput("ovf_count", 32'(count_out), 32'd8);
        checkOutput("ovf_flag", 32'(overflow_out), 32'd1);
        checkOutput("ovf_head", 32'(data_out), 32'h50);
        drain(7);
        checkOutput("ovf_tail", 32'(data_out), 32'h57);
        drain(1);
        checkOutput("ovf_empty", 32'(count_out), 32'd0);
        checkOutput("ovf_sticky", 32'(overflow_out), 32'd1);
        pulseReset();
        checkOutput("ovf_cleared", 32'(overflow_out), 32'd0);

        // Capture and pop on the same edge while full.
        for (int i = 0; i < 8; i++) pulseStrobe(BW'(8'h60 + i), 1'b0);
        applyStimulus(1'b1, 8'h77, 1'b1);
        checkOutput("fullpp_count", 32'(count_out), 32'd8);
        checkOutput("fullpp_overflow", 32'(overflow_out), 32'd0);
        checkOutput("fullpp_head", 32'(data_out), 32'h61);
        drain(7);
        checkOutput("fullpp_new_last", 32'(data_out), 32'h77);
        checkOutput("fullpp_count1", 32'(count_out), 32'd1);
        drain(1);

        // Frame tagging from a clean position with random stalls.
        pulseReset();
        runFrame(1'b1, "frame");

        // Reset mid-frame discards contents and restarts the position.
        for (int i = 0; i < 3; i++) pulseStrobe(BW'(8'hA0 + i), 1'b0);
        checkOutput("mid_queued", 32'(count_out), 32'd3);
        pulseReset();
        checkOutput("mid_valid", 32'(valid_out), 32'd0);
        checkOutput("mid_count", 32'(count_out), 32'd0);
        checkOutput("mid_overflow", 32'(overflow_out), 32'd0);
        runFrame(1'b0, "mid_frame");

        // Strobe already high when reset releases still counts as a rising edge.
        reset           = 1'b1;
        averageReady_in = 1'b1;
        average_in      = 8'hC3;
        ready_in        = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("release_count", 32'(count_out), 32'd1);
        checkOutput("release_data", 32'(data_out), 32'hC3);
        applyStimulus(1'b1, 8'hC4, 1'b0);
        checkOutput("release_no_recapture", 32'(count_out), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        drain(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pool_result_collector.md
POOL_RESULT_COLLECTOR -- requirements
Module: pool_result_collector

Interface
REQ-001 Parameter: bitwidth, default 8, width of each pooled result.
REQ-002 Parameter: outWidth, default 4, pooled results per output row.
REQ-003 Parameter: outHeight, default 4, pooled rows per frame.
REQ-004 Parameter: depth, default 8, FIFO entries; SHALL be a power of two, at least 2.
REQ-005 clock  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 average_in  in  bitwidth  pooled result from the average-pooling stage.
REQ-008 averageReady_in  in  1  result strobe from the pooling stage; a rising edge marks one new result.
REQ-009 data_out  out  bitwidth  head-of-FIFO result.
REQ-010 valid_out  out  1  data_out holds a result.
REQ-011 ready_in  in  1  downstream accepts data_out this cycle.
REQ-012 last_out  out  1  data_out is the final result of a frame; qualified by valid_out.
REQ-013 count_out  out  $clog2(depth)+1  current FIFO occupancy.
REQ-014 overflow_out  out  1  sticky flag; a result was dropped because the FIFO was full.

Function
REQ-015 Edge detect: a registered copy of averageReady_in SHALL be kept; capture = averageReady_in AND NOT registered copy; a held-high strobe yields exactly one capture.
REQ-016 Capture SHALL sample average_in in the same cycle the capture pulse is high.
REQ-017 Push occurs on capture when the FIFO is not full, or when full and a pop occurs in the same cycle.
REQ-018 Capture while full without a simultaneous pop SHALL drop the value and set overflow_out the next cycle; overflow_out clears only on reset.
REQ-019 Pop occurs when valid_out AND ready_in; data_out SHALL advance to the next entry the following cycle.
REQ-020 FIFO SHALL be first-word-fall-through: valid_out = (count != 0); data_out = mem[rd_ptr].
REQ-021 Latency: a result captured into an empty FIFO SHALL appear on data_out with valid_out high exactly one cycle later.
REQ-022 Push and pop in the same cycle SHALL leave count_out unchanged; this holds when full (pop precedes push) and at count 1.
REQ-023 Capture into an empty FIFO with ready_in high SHALL NOT bypass; the value becomes visible the next cycle.
REQ-024 Read and write pointers SHALL be $clog2(depth) bits and wrap from depth-1 to 0.
REQ-025 Position counters col (0..outWidth-1) and row (0..outHeight-1) SHALL advance on each pop only; col wraps to 0 and increments row; row wraps to 0 after outHeight-1.
REQ-026 last_out = valid_out AND col == outWidth-1 AND row == outHeight-1.
REQ-027 When ready_in is low, data_out, valid_out and last_out SHALL hold stable while valid_out is high.

Reset
REQ-028 Reset SHALL force pointers, count_out, col, row, overflow_out and the strobe register to 0; valid_out and last_out read 0.
REQ-029 Reset asserted mid-frame SHALL discard FIFO contents; the FIFO memory need not be cleared.
REQ-030 If averageReady_in is high when reset releases, the first active edge SHALL see it as a rising edge and capture one result.

Verification
REQ-031 Scenario single: strobe 0->1 with average_in=0x2A, ready_in=0 -> next cycle valid_out=1, data_out=0x2A, count_out=1.
REQ-032 Scenario held strobe: averageReady_in high for 5 cycles with changing average_in -> exactly one capture, count_out=1.
REQ-033 Scenario overflow, depth=8: 9 strobes, ready_in=0 -> count_out=8, overflow_out=1; drained values are the first 8 in order.
REQ-034 Scenario full push+pop: full FIFO, ready_in=1 and capture in the same cycle -> count_out stays 8, overflow_out stays 0, the new value exits last.
REQ-035 Scenario frame, 4x4: 16 results popped with random ready_in stalls -> last_out high only on the 16th, col/row back to 0, 17th pop has last_out=0.
REQ-036 Scenario reset mid-frame: 3 entries queued, reset pulse -> valid_out=0, count_out=0, overflow_out=0; next capture pops with col=0, row=0.
